// File: rtl/tim_pkg.sv
// Shared definitions for the timer interrupt servicer: FSM encoding and default widths.
package tim_pkg;

    // Default width of counter / compare / period values.
    localparam int unsigned CntWidthDefault = 64;

    // Servicer FSM states.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StCalc   = 3'd1,
        StWrite  = 3'd2,
        StClear  = 3'd3,
        StSettle = 3'd4
    } tim_state_e;

endpackage

// File: rtl/tim_ack_timer.sv
// Loadable down-counter bounding how long a compare write waits for its ack.
// 'last' is high while the counter holds 1, i.e. during the final permitted wait cycle.
module tim_ack_timer #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic load,
    input  logic dec,
    output logic last
);

    localparam int unsigned TmrWidth = $clog2(ACK_TIMEOUT + 1);

    logic [TmrWidth-1:0] count_q;
    logic [TmrWidth-1:0] count_d;

    // Next count: reload on request, otherwise count down and park at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = TmrWidth'(ACK_TIMEOUT);
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - TmrWidth'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Timeout indication for the current wait cycle.
    always_comb begin
        last = (count_q == TmrWidth'(1));
    end

endmodule

// File: rtl/tim_int_service.sv
// Timer interrupt servicer: on tim_int computes compare_val + period, writes it back over a
// req/ack handshake, pulses int_clr, counts services and flags overruns / write timeouts.
module tim_int_service
    import tim_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = CntWidthDefault,
    parameter int unsigned SVC_WIDTH   = 16,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 enable,
    input  logic                 tim_int,
    input  logic [CNT_WIDTH-1:0] cnt_val,
    input  logic [CNT_WIDTH-1:0] compare_val,
    input  logic [CNT_WIDTH-1:0] period,
    output logic                 cmp_wr_req,
    output logic [CNT_WIDTH-1:0] cmp_wr_data,
    input  logic                 cmp_wr_ack,
    output logic                 int_clr,
    output logic                 busy,
    output logic [SVC_WIDTH-1:0] svc_cnt,
    output logic                 overrun,
    output logic                 timeout_err,
    input  logic                 err_clr
);

    tim_state_e state_q;
    tim_state_e state_d;

    logic [CNT_WIDTH-1:0] cmp_wr_data_q;
    logic [SVC_WIDTH-1:0] svc_cnt_q;
    logic                 overrun_q;
    logic                 timeout_err_q;

    logic [CNT_WIDTH-1:0] next_cmp;
    logic [CNT_WIDTH-1:0] delta;
    logic                 overrun_set;
    logic                 timeout_set;
    logic                 tmr_load;
    logic                 tmr_dec;
    logic                 tmr_last;

    // Next compare value and its distance from the live counter, both modulo 2^CNT_WIDTH.
    // A distance larger than one period means the counter has already passed the new compare.
    always_comb begin
        next_cmp    = compare_val + period;
        delta       = next_cmp - cnt_val;
        overrun_set = (state_q == StCalc) && (period != '0) && (delta > period);
        // Ack on the final wait cycle still counts as a successful write.
        timeout_set = (state_q == StWrite) && !cmp_wr_ack && tmr_last;
        tmr_load    = (state_q == StCalc);
        tmr_dec     = (state_q == StWrite) && !cmp_wr_ack;
    end

    tim_ack_timer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_ack_timer (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .load   (tmr_load),
        .dec    (tmr_dec),
        .last   (tmr_last)
    );

    // FSM state register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; once started a sequence always runs to SETTLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (enable && tim_int) begin
                    state_d = StCalc;
                end
            end
            StCalc: begin
                // A zero period is one-shot: nothing to rewrite.
                state_d = (period == '0) ? StClear : StWrite;
            end
            StWrite: begin
                if (cmp_wr_ack || tmr_last) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                state_d = StSettle;
            end
            StSettle: begin
                // Gives the timer one cycle to drop its pending status before re-arming.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM output decode.
    always_comb begin
        cmp_wr_req = (state_q == StWrite);
        int_clr    = (state_q == StClear);
        busy       = (state_q != StIdle);
    end

    // Write data, service counter and sticky error flags; a set beats a coincident err_clr.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cmp_wr_data_q <= '0;
            svc_cnt_q     <= '0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state_q == StCalc) begin
                cmp_wr_data_q <= next_cmp;
            end
            if (state_q == StClear) begin
                svc_cnt_q <= svc_cnt_q + SVC_WIDTH'(1);
            end
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (err_clr) begin
                overrun_q <= 1'b0;
            end
            if (timeout_set) begin
                timeout_err_q <= 1'b1;
            end else if (err_clr) begin
                timeout_err_q <= 1'b0;
            end
        end
    end

    // Register-backed outputs.
    always_comb begin
        cmp_wr_data = cmp_wr_data_q;
        svc_cnt     = svc_cnt_q;
        overrun     = overrun_q;
        timeout_err = timeout_err_q;
    end

endmodule

// File: tb/tb_tim_int_service.sv
// Directed self-checking bench for tim_int_service. dut_a uses the default ack timeout,
// dut_t a short timeout of 4 cycles; both share all inputs.
module tb_tim_int_service;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        enable;
    logic        tim_int;
    logic [63:0] cnt_val;
    logic [63:0] compare_val;
    logic [63:0] period;
    logic        cmp_wr_ack;
    logic        err_clr;

    logic        req_a, int_clr_a, busy_a, overrun_a, timeout_a;
    logic [63:0] data_a;
    logic [15:0] svc_a;
    logic        req_t, int_clr_t, busy_t, overrun_t, timeout_t;
    logic [63:0] data_t;
    logic [15:0] svc_t;

    int errors = 0;
    int checks = 0;

    always #5 sys_clk = ~sys_clk;

    tim_int_service #(.CNT_WIDTH(64), .SVC_WIDTH(16), .ACK_TIMEOUT(255)) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable), .tim_int(tim_int),
        .cnt_val(cnt_val), .compare_val(compare_val), .period(period),
        .cmp_wr_req(req_a), .cmp_wr_data(data_a), .cmp_wr_ack(cmp_wr_ack),
        .int_clr(int_clr_a), .busy(busy_a), .svc_cnt(svc_a), .overrun(overrun_a),
        .timeout_err(timeout_a), .err_clr(err_clr)
    );

    tim_int_service #(.CNT_WIDTH(64), .SVC_WIDTH(16), .ACK_TIMEOUT(4)) dut_t (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable), .tim_int(tim_int),
        .cnt_val(cnt_val), .compare_val(compare_val), .period(period),
        .cmp_wr_req(req_t), .cmp_wr_data(data_t), .cmp_wr_ack(cmp_wr_ack),
        .int_clr(int_clr_t), .busy(busy_t), .svc_cnt(svc_t), .overrun(overrun_t),
        .timeout_err(timeout_t), .err_clr(err_clr)
    );

    // Advance one clock; inputs change and outputs are sampled at the falling edge.
    task automatic tick;
        @(negedge sys_clk);
    endtask

    task automatic test_reset;
        sys_rst = 1'b1; enable = 1'b0; tim_int = 1'b0; cmp_wr_ack = 1'b0; err_clr = 1'b0;
        cnt_val = '0; compare_val = '0; period = '0;
        tick(); tick();
        sys_rst = 1'b0;
        checks++; if (req_a !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", req_a); end
        checks++; if (int_clr_a !== 1'b0) begin errors++; $display("FAIL reset_int_clr: got %0b want 0", int_clr_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy_a); end
        checks++; if (svc_a !== 16'd0) begin errors++; $display("FAIL reset_svc: got %0d want 0", svc_a); end
        checks++; if (data_a !== 64'd0) begin errors++; $display("FAIL reset_data: got %0h want 0", data_a); end
        checks++; if ({overrun_a, timeout_a} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b want 00", {overrun_a, timeout_a}); end
        checks++; if (busy_t !== 1'b0) begin errors++; $display("FAIL reset_busy_t: got %0b want 0", busy_t); end
    endtask

    task automatic test_periodic;
        enable = 1'b1; compare_val = 64'd100; period = 64'd50; cnt_val = 64'd100;
        cmp_wr_ack = 1'b1;  // held high: an ack while req is low must be ignored
        tim_int = 1'b1;
        tick();  // CALC
        tim_int = 1'b0;
        checks++; if ({busy_a, req_a, int_clr_a} !== 3'b100) begin errors++; $display("FAIL periodic_calc: got %b want 100", {busy_a, req_a, int_clr_a}); end
        tick();  // WRITE
        checks++; if (req_a !== 1'b1) begin errors++; $display("FAIL periodic_req: got %0b want 1", req_a); end
        checks++; if (data_a !== 64'd150) begin errors++; $display("FAIL periodic_data: got %0d want 150", data_a); end
        tick();  // CLEAR
        checks++; if ({req_a, int_clr_a} !== 2'b01) begin errors++; $display("FAIL periodic_clr: got %b want 01", {req_a, int_clr_a}); end
        tick();  // SETTLE
        checks++; if ({busy_a, int_clr_a} !== 2'b10) begin errors++; $display("FAIL periodic_settle: got %b want 10", {busy_a, int_clr_a}); end
        checks++; if (svc_a !== 16'd1) begin errors++; $display("FAIL periodic_svc: got %0d want 1", svc_a); end
        tick();  // IDLE
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL periodic_idle: got %0b want 0", busy_a); end
        checks++; if (overrun_a !== 1'b0) begin errors++; $display("FAIL periodic_overrun: got %0b want 0", overrun_a); end
        cmp_wr_ack = 1'b0;
    endtask

    task automatic test_delayed_ack;
        compare_val = 64'd100; period = 64'd50; cnt_val = 64'd100;
        tim_int = 1'b1;
        tick();
        tim_int = 1'b0;
        tick();  // WRITE, first req cycle
        for (int i = 0; i < 7; i++) begin
            checks++; if ({req_a, data_a} !== {1'b1, 64'd150}) begin errors++; $display("FAIL delayed_hold%0d: got req=%0b data=%0d want req=1 data=150", i, req_a, data_a); end
            if (i == 6) cmp_wr_ack = 1'b1;
            tick();
        end
        cmp_wr_ack = 1'b0;
        checks++; if ({req_a, int_clr_a} !== 2'b01) begin errors++; $display("FAIL delayed_clr: got %b want 01", {req_a, int_clr_a}); end
        checks++; if (timeout_a !== 1'b0) begin errors++; $display("FAIL delayed_timeout: got %0b want 0", timeout_a); end
        tick(); tick();
        checks++; if ({busy_a, svc_a} !== {1'b0, 16'd2}) begin errors++; $display("FAIL delayed_end: got busy=%0b svc=%0d want busy=0 svc=2", busy_a, svc_a); end
    endtask

    task automatic test_timeout;
        // dut_t already timed out during the delayed-ack scenario; clear it first.
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        checks++; if (timeout_t !== 1'b0) begin errors++; $display("FAIL timeout_preclear: got %0b want 0", timeout_t); end
        tim_int = 1'b1;
        tick();
        tim_int = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if ({req_t, timeout_t} !== 2'b10) begin errors++; $display("FAIL timeout_wait%0d: got %b want 10", i, {req_t, timeout_t}); end
            tick();
        end
        checks++; if ({req_t, int_clr_t, timeout_t} !== 3'b011) begin errors++; $display("FAIL timeout_fire: got %b want 011", {req_t, int_clr_t, timeout_t}); end
        tick(); tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        checks++; if (timeout_t !== 1'b0) begin errors++; $display("FAIL timeout_errclr: got %0b want 0", timeout_t); end
        // dut_a is still waiting within its long timeout; finish it with an ack.
        checks++; if (req_a !== 1'b1) begin errors++; $display("FAIL timeout_a_waiting: got %0b want 1", req_a); end
        cmp_wr_ack = 1'b1; tick(); cmp_wr_ack = 1'b0;
        checks++; if ({int_clr_a, timeout_a} !== 2'b10) begin errors++; $display("FAIL timeout_a_clr: got %b want 10", {int_clr_a, timeout_a}); end
        tick(); tick();
        checks++; if ({busy_a, svc_a} !== {1'b0, 16'd3}) begin errors++; $display("FAIL timeout_a_end: got busy=%0b svc=%0d want busy=0 svc=3", busy_a, svc_a); end
    endtask

    task automatic test_overrun_wrap;
        cmp_wr_ack = 1'b1;
        compare_val = 64'hFFFF_FFFF_FFFF_FFF0; period = 64'h20; cnt_val = 64'hFFFF_FFFF_FFFF_FFF0;
        tim_int = 1'b1; tick(); tim_int = 1'b0;
        tick();
        checks++; if (data_a !== 64'h10) begin errors++; $display("FAIL wrap_data: got %0h want 10", data_a); end
        checks++; if (overrun_a !== 1'b0) begin errors++; $display("FAIL wrap_overrun: got %0b want 0", overrun_a); end
        tick(); tick(); tick();
        // err_clr lands on the same edge as the overrun set: the set must win.
        cnt_val = 64'h40; compare_val = 64'h10; period = 64'h20;
        tim_int = 1'b1; tick(); tim_int = 1'b0;
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        checks++; if (overrun_a !== 1'b1) begin errors++; $display("FAIL overrun_set: got %0b want 1", overrun_a); end
        checks++; if (data_a !== 64'h30) begin errors++; $display("FAIL overrun_data: got %0h want 30", data_a); end
        tick(); tick(); tick();
        checks++; if (overrun_a !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %0b want 1", overrun_a); end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        checks++; if (overrun_a !== 1'b0) begin errors++; $display("FAIL overrun_clr: got %0b want 0", overrun_a); end
        checks++; if (svc_a !== 16'd5) begin errors++; $display("FAIL overrun_svc: got %0d want 5", svc_a); end
        cmp_wr_ack = 1'b0;
    endtask

    task automatic test_one_shot;
        period = 64'd0; compare_val = 64'd100; cnt_val = 64'd200;
        tim_int = 1'b1; tick(); tim_int = 1'b0;
        checks++; if ({busy_a, req_a} !== 2'b10) begin errors++; $display("FAIL oneshot_calc: got %b want 10", {busy_a, req_a}); end
        tick();
        checks++; if ({req_a, int_clr_a} !== 2'b01) begin errors++; $display("FAIL oneshot_clr: got %b want 01", {req_a, int_clr_a}); end
        checks++; if (overrun_a !== 1'b0) begin errors++; $display("FAIL oneshot_overrun: got %0b want 0", overrun_a); end
        tick();
        checks++; if ({req_a, int_clr_a, svc_a} !== {2'b00, 16'd6}) begin errors++; $display("FAIL oneshot_settle: got req=%0b clr=%0b svc=%0d want 0 0 6", req_a, int_clr_a, svc_a); end
        tick();
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL oneshot_idle: got %0b want 0", busy_a); end
    endtask

    task automatic test_enable_drop;
        period = 64'd50; compare_val = 64'd100; cnt_val = 64'd100; cmp_wr_ack = 1'b1;
        tim_int = 1'b1; tick();
        enable = 1'b0;  // tim_int stays high throughout
        tick(); tick();
        checks++; if (int_clr_a !== 1'b1) begin errors++; $display("FAIL enable_complete: got %0b want 1", int_clr_a); end
        tick(); tick(); tick(); tick();
        checks++; if ({busy_a, svc_a} !== {1'b0, 16'd7}) begin errors++; $display("FAIL enable_norestart: got busy=%0b svc=%0d want busy=0 svc=7", busy_a, svc_a); end
        tim_int = 1'b0; enable = 1'b1; cmp_wr_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_write;
        period = 64'd50; compare_val = 64'd100; cnt_val = 64'd100; cmp_wr_ack = 1'b0;
        tim_int = 1'b1; tick(); tim_int = 1'b0;
        tick(); tick();
        checks++; if (req_a !== 1'b1) begin errors++; $display("FAIL rstmid_inwrite: got %0b want 1", req_a); end
        sys_rst = 1'b1; tick(); sys_rst = 1'b0;
        checks++; if ({req_a, busy_a, svc_a} !== {2'b00, 16'd0}) begin errors++; $display("FAIL rstmid_state: got req=%0b busy=%0b svc=%0d want 0 0 0", req_a, busy_a, svc_a); end
        checks++; if (data_a !== 64'd0) begin errors++; $display("FAIL rstmid_data: got %0h want 0", data_a); end
        cmp_wr_ack = 1'b1;
        tim_int = 1'b1; tick(); tim_int = 1'b0;
        tick();
        checks++; if ({req_a, data_a} !== {1'b1, 64'd150}) begin errors++; $display("FAIL rstmid_restart: got req=%0b data=%0d want 1 150", req_a, data_a); end
        tick();
        checks++; if (int_clr_a !== 1'b1) begin errors++; $display("FAIL rstmid_clr: got %0b want 1", int_clr_a); end
        tick(); tick();
        checks++; if ({busy_a, svc_a} !== {1'b0, 16'd1}) begin errors++; $display("FAIL rstmid_end: got busy=%0b svc=%0d want 0 1", busy_a, svc_a); end
        cmp_wr_ack = 1'b0;
    endtask

    initial begin
        tick();
        test_reset();
        test_periodic();
        test_delayed_ack();
        test_timeout();
        test_overrun_wrap();
        test_one_shot();
        test_enable_drop();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
